// File: rtl/fb_swap_ctrl.sv
// fb_swap_ctrl: 2/3-deep framebuffer controller with tear-free swaps and coordinate-to-address mapping
// Ports: i_clk, i_reset (sync, active-high); i_new_frame vblank pulse;
//   i_out_x/i_out_y -> o_rd_addr/o_rd_valid (display read, registered);
//   i_render_x/i_render_y/i_render_we -> o_wr_addr/o_wr_en (renderer write, registered);
//   i_render_done/o_render_ack frame handshake; o_stall finished frame waiting for a swap;
//   o_disp_buf/o_rend_buf buffer indices; o_frames_repeated vblanks without a fresh frame.
// Macro FB_STATS_EN builds the saturating repeat counter; otherwise o_frames_repeated is 0.
module fb_swap_ctrl #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int COORD_W = 9,
  parameter int NUM_BUFS = 3,
  parameter int ADDR_W = $clog2(NUM_BUFS * SCREEN_W * SCREEN_H)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_new_frame,
  input  logic [COORD_W-1:0] i_out_x,
  input  logic [COORD_W-1:0] i_out_y,
  output logic [ADDR_W-1:0]  o_rd_addr,
  output logic               o_rd_valid,
  input  logic [COORD_W-1:0] i_render_x,
  input  logic [COORD_W-1:0] i_render_y,
  input  logic               i_render_we,
  output logic [ADDR_W-1:0]  o_wr_addr,
  output logic               o_wr_en,
  input  logic               i_render_done,
  output logic               o_render_ack,
  output logic               o_stall,
  output logic [1:0]         o_disp_buf,
  output logic [1:0]         o_rend_buf,
  output logic [7:0]         o_frames_repeated
);
  if (NUM_BUFS != 2 && NUM_BUFS != 3) begin : g_bad_bufs
    $error("fb_swap_ctrl: NUM_BUFS must be 2 or 3");
  end
  localparam bit TRI = NUM_BUFS == 3;
  localparam logic [COORD_W:0] LIM_X = (COORD_W+1)'(SCREEN_W);
  localparam logic [COORD_W:0] LIM_Y = (COORD_W+1)'(SCREEN_H);
  typedef enum logic [2:0] {RENDERING, WAIT_SWAP, SWAP, ACK, DRAIN} state_t;
  state_t r_state, w_next;
  logic [1:0] r_disp, r_rend, r_ready, r_free;
  logic [1:0] w_disp, w_rend, w_ready, w_free, w_rend_rot, w_ready_rot;
  logic r_rv, w_rv, w_rv_rot, w_rot, w_dswap, w_tswap;
  logic r_ack, r_stall, r_rd_valid, r_wr_en;
  logic [ADDR_W-1:0] r_rd_addr, r_wr_addr;
  logic w_rd_ok, w_wr_ok;
  function automatic logic [ADDR_W-1:0] f_addr(input logic [1:0] b, input logic [COORD_W-1:0] x,
                                               input logic [COORD_W-1:0] y, input logic ok);
    f_addr = ADDR_W'(b) * ADDR_W'(SCREEN_W * SCREEN_H)
           + (ok ? ADDR_W'(y) * ADDR_W'(SCREEN_W) + ADDR_W'(x) : '0);
  endfunction
  assign w_rd_ok = {1'b0, i_out_x} < LIM_X && {1'b0, i_out_y} < LIM_Y;
  assign w_wr_ok = {1'b0, i_render_x} < LIM_X && {1'b0, i_render_y} < LIM_Y;
  // Triple-buffer rotation happens on the cycle done is accepted, so a coincident
  // new_frame can already show the fresh frame; SWAP only spaces out the ack.
  always_comb begin
    w_next = r_state;
    w_rot = 1'b0;
    w_dswap = 1'b0;
    case (r_state)
      RENDERING: begin
        w_rot = TRI && i_render_done;
        w_dswap = !TRI && i_render_done && i_new_frame;
        w_next = !i_render_done ? RENDERING : TRI ? SWAP : i_new_frame ? ACK : WAIT_SWAP;
      end
      WAIT_SWAP: begin
        w_dswap = i_new_frame;
        w_next = i_new_frame ? ACK : WAIT_SWAP;
      end
      SWAP: w_next = ACK;
      ACK: w_next = DRAIN;
      DRAIN: w_next = i_render_done ? DRAIN : RENDERING;
      default: w_next = RENDERING;
    endcase
    w_rend_rot = w_rot ? (r_rv ? r_ready : r_free) : r_rend;
    w_ready_rot = w_rot ? r_rend : r_ready;
    w_rv_rot = w_rot | r_rv;
    w_tswap = TRI && i_new_frame && w_rv_rot;
    w_disp = w_dswap ? r_rend : w_tswap ? w_ready_rot : r_disp;
    w_rend = w_dswap ? r_disp : w_rend_rot;
    w_ready = w_ready_rot;
    w_free = w_tswap ? r_disp : r_free;
    w_rv = w_rv_rot & ~w_tswap;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= RENDERING;
      r_disp <= 2'd0;
      r_rend <= 2'd1;
      r_ready <= 2'd0;
      r_free <= 2'd2;
      r_rv <= 1'b0;
      r_ack <= 1'b0;
      r_stall <= 1'b0;
      r_rd_addr <= '0;
      r_rd_valid <= 1'b0;
      r_wr_addr <= '0;
      r_wr_en <= 1'b0;
    end else begin
      r_state <= w_next;
      r_disp <= w_disp;
      r_rend <= w_rend;
      r_ready <= w_ready;
      r_free <= w_free;
      r_rv <= w_rv;
      r_ack <= w_next == ACK;
      r_stall <= w_next == WAIT_SWAP;
      r_rd_addr <= f_addr(r_disp, i_out_x, i_out_y, w_rd_ok);
      r_rd_valid <= w_rd_ok;
      r_wr_addr <= f_addr(r_rend, i_render_x, i_render_y, w_wr_ok);
      r_wr_en <= i_render_we && w_wr_ok && r_state == RENDERING;
    end
  end
`ifdef FB_STATS_EN
  logic [7:0] r_rep;
  always_ff @(posedge i_clk) begin
    if (i_reset) r_rep <= '0;
    else if (i_new_frame && w_disp == r_disp && r_rep != 8'hff) r_rep <= r_rep + 8'd1;
  end
  assign o_frames_repeated = r_rep;
`else
  assign o_frames_repeated = '0;
`endif
  assign o_rd_addr = r_rd_addr;
  assign o_rd_valid = r_rd_valid;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_en = r_wr_en;
  assign o_render_ack = r_ack;
  assign o_stall = r_stall;
  assign o_disp_buf = r_disp;
  assign o_rend_buf = r_rend;
endmodule
